mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum BUSY cycles allowed per access (range 1..255).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 xm_valid  in  1  X/M stage holds a real instruction.
REQ-005 xm_MemRead, xm_MemWrite, xm_halt  in  1 each  X/M control signals.
REQ-006 xm_addr, xm_wdata  in  16 each  access address and store data.
REQ-007 mem_req  out  1  memory request, held until mem_ready.
REQ-008 mem_wr  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 mem_addr, mem_wdata  out  16 each  request address and data.
REQ-010 mem_rdata  in  16; mem_ready  in  1  (completion, any latency including 0).
REQ-011 stall  out  1  freeze F/D/X stages and the X/M register.
REQ-012 mw_en  out  1  write enable for the M/W pipeline register.
REQ-013 mw_bubble  out  1  M/W SHALL load a NOP (RegWrite=0, halt=0) when set.
REQ-014 mw_mem_data  out  16  load data to M/W mem input.
REQ-015 halted, err  out  1 each  sticky status; stall_cycles  out  16  stall counter.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, ERROR.
REQ-017 Access = xm_valid & (xm_MemRead | xm_MemWrite) & !halted; MemWrite SHALL take priority when both are set (mem_wr=1).
REQ-018 IDLE, access: mem_req=1, mem_addr/mem_wdata=xm_addr/xm_wdata (combinational), both latched at the clock edge.
REQ-019 IDLE, access, mem_ready=1 (zero-wait): stall=0, mw_en=1, mw_bubble=0, remain IDLE.
REQ-020 IDLE, access, mem_ready=0: stall=1, mw_en=1, mw_bubble=1, go to BUSY with wait_cnt=0.
REQ-021 BUSY: mem_req=1 with latched address/data/mem_wr; stall=1, mw_en=1, mw_bubble=1 while mem_ready=0; wait_cnt increments per cycle.
REQ-022 BUSY, mem_ready=1: stall=0, mw_en=1, mw_bubble=0, go IDLE; mem_ready on the cycle with wait_cnt=TIMEOUT-1 SHALL still complete normally.
REQ-023 BUSY, mem_ready=0, wait_cnt=TIMEOUT-1: go ERROR next cycle.
REQ-024 ERROR: mem_req=0, stall=1, mw_en=1, mw_bubble=1, err=1; exited only by reset.
REQ-025 mw_mem_data SHALL equal mem_rdata in the cycle a read completes, else 0x0000.
REQ-026 IDLE, xm_valid & no memory op & !halted: stall=0, mw_en=1, mw_bubble=0 (pass-through).
REQ-027 IDLE, xm_valid=0: stall=0, mw_en=1, mw_bubble=1.
REQ-028 halted SHALL set on the edge after the cycle a xm_halt instruction is passed to M/W with mw_bubble=0 (after its access if any); once halted: mem_req=0, stall=1, mw_en=1, mw_bubble=1.
REQ-029 stall_cycles SHALL increment each cycle stall=1, saturating at 0xFFFF.

Reset
REQ-030 At a clock edge with rst=1: state=IDLE, wait_cnt=0, halted=0, err=0, stall_cycles=0, latched address/data=0.
REQ-031 While rst=1: mem_req=0, mw_en=0, stall=0, mw_bubble=1, mw_mem_data=0x0000.
REQ-032 Reset during BUSY SHALL abandon the access; mem_req=0 from the reset cycle onward, no completion reported.

Verification
REQ-033 Zero-wait load: xm_MemRead, addr 0x0040, mem_ready=1 same cycle, mem_rdata 0xBEEF -> mw_en=1, mw_bubble=0, mw_mem_data=0xBEEF, stall=0, stall_cycles=0.
REQ-034 3-cycle store: xm_MemWrite, addr 0x0102, wdata 0x1234, mem_ready on 4th cycle -> mem_req held 4 cycles with mem_wr=1, address/data stable, 3 bubble cycles, stall_cycles=3.
REQ-035 Timeout: TIMEOUT=4, read, mem_ready never -> ERROR after 4 BUSY cycles, err=1, mem_req=0; mem_ready on the 4th BUSY cycle instead -> normal completion, err=0.
REQ-036 Halt: pass-through ALU op, then xm_halt -> halt passed with mw_bubble=0, halted=1 next cycle; later xm_MemRead -> mem_req stays 0.
REQ-037 Reset mid-BUSY: rst on 2nd BUSY cycle -> mem_req=0, state IDLE, stall_cycles=0; next load completes normally.
REQ-038 Both MemRead and MemWrite set -> mem_wr=1, mw_mem_data=0x0000 on completion.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: X/M request, memory bus and M/W control signals of the memory stage.
interface mem_stage_if;
    logic        xm_valid, xm_MemRead, xm_MemWrite, xm_halt;
    logic [15:0] xm_addr, xm_wdata;
    logic        mem_req, mem_wr, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, mw_en, mw_bubble, halted, err;
    logic [15:0] mw_mem_data, stall_cycles;
    modport master(
        input  xm_valid, xm_MemRead, xm_MemWrite, xm_halt, xm_addr, xm_wdata, mem_rdata, mem_ready,
        output mem_req, mem_wr, mem_addr, mem_wdata, stall, mw_en, mw_bubble, mw_mem_data,
               halted, err, stall_cycles
    );
    modport slave(
        output xm_valid, xm_MemRead, xm_MemWrite, xm_halt, xm_addr, xm_wdata, mem_rdata, mem_ready,
        input  mem_req, mem_wr, mem_addr, mem_wdata, stall, mw_en, mw_bubble, mw_mem_data,
               halted, err, stall_cycles
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller issuing bus accesses and stalling the pipeline
// until completion, with per-access timeout, sticky halt and error status.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_stage_if.master  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;
    localparam logic [7:0] WAIT_LAST = TIMEOUT[7:0] - 8'd1;
    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_halted, r_wr;
    logic [15:0] r_stall_cycles, r_addr, r_wdata;
    logic        w_access, w_req, w_wr, w_stall, w_bubble, w_done;
    logic [15:0] w_addr, w_wdata;
    always_comb begin
        w_access = bus.xm_valid & (bus.xm_MemRead | bus.xm_MemWrite) & !r_halted;
        w_req    = 1'b0;
        w_wr     = r_wr;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_stall  = 1'b0;
        w_bubble = 1'b1;
        w_done   = 1'b0;
        if (rst) begin
            w_stall = 1'b0;
        end else if (r_state == ERROR || (r_state == IDLE && r_halted)) begin
            w_stall = 1'b1;
        end else if (r_state == BUSY || w_access) begin
            w_req    = 1'b1;
            w_done   = bus.mem_ready;
            w_stall  = !bus.mem_ready;
            w_bubble = !bus.mem_ready;
            if (r_state == IDLE) begin
                w_wr    = bus.xm_MemWrite;
                w_addr  = bus.xm_addr;
                w_wdata = bus.xm_wdata;
            end
        end else begin
            w_bubble = !bus.xm_valid;
        end
    end
    assign bus.mem_req      = w_req;
    assign bus.mem_wr       = w_req & w_wr;
    assign bus.mem_addr     = w_addr;
    assign bus.mem_wdata    = w_wdata;
    assign bus.stall        = w_stall;
    assign bus.mw_en        = !rst;
    assign bus.mw_bubble    = w_bubble;
    assign bus.mw_mem_data  = (w_done && !w_wr) ? bus.mem_rdata : 16'h0000;
    assign bus.halted       = r_halted;
    assign bus.err          = (r_state == ERROR);
    assign bus.stall_cycles = r_stall_cycles;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wait_cnt     <= 8'd0;
            r_halted       <= 1'b0;
            r_wr           <= 1'b0;
            r_stall_cycles <= 16'd0;
            r_addr         <= 16'd0;
            r_wdata        <= 16'd0;
        end else begin
            if (w_stall && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            // A halt retires only when it actually enters M/W, i.e. after its access completes.
            if (!w_bubble && bus.xm_valid && bus.xm_halt)
                r_halted <= 1'b1;
            if (r_state == IDLE && w_access) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_wr    <= w_wr;
            end
            case (r_state)
                IDLE: if (w_access && !bus.mem_ready) begin
                    r_state    <= BUSY;
                    r_wait_cnt <= 8'd0;
                end
                BUSY: if (bus.mem_ready) r_state <= IDLE;
                      else if (r_wait_cnt == WAIT_LAST) r_state <= ERROR;
                      else r_wait_cnt <= r_wait_cnt + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scenarios plus randomized traffic checked against a
// transaction-level model of the memory stage.
module tb_mem_stage_ctrl;
    localparam int TMO = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_stage_if bus();
    mem_stage_ctrl #(.TIMEOUT(TMO)) dut(.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0, n_bad = 0;
    bit m_pend, m_halted, m_err, m_wr, last_stall;
    int m_busy, m_stalls;
    logic [15:0] m_addr, m_wdata;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input bit r, input bit v, input bit rd, input bit wr, input bit h,
                       input logic [15:0] a, input logic [15:0] d,
                       input bit rdy, input logic [15:0] rdat);
        bit acc, e_req, e_wr, e_stall, e_bub, e_done;
        logic [15:0] e_addr, e_wd;
        rst = r;
        bus.xm_valid = v; bus.xm_MemRead = rd; bus.xm_MemWrite = wr; bus.xm_halt = h;
        bus.xm_addr = a; bus.xm_wdata = d; bus.mem_ready = rdy; bus.mem_rdata = rdat;
        #4;
        acc = v && (rd || wr) && !m_halted;
        e_req = 0; e_wr = m_wr; e_addr = m_addr; e_wd = m_wdata;
        e_stall = 0; e_bub = 1; e_done = 0;
        if (r) e_stall = 0;
        else if (m_err) e_stall = 1;
        else if (m_pend) e_req = 1;
        else if (m_halted) e_stall = 1;
        else if (acc) begin e_req = 1; e_wr = wr; e_addr = a; e_wd = d; end
        else e_bub = !v;
        if (e_req) begin e_done = rdy; e_stall = !rdy; e_bub = !rdy; end
        chk("mem_req", 32'(bus.mem_req), 32'(e_req));
        if (e_req) begin
            chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        end
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("mw_en", 32'(bus.mw_en), 32'(!r));
        chk("mw_bubble", 32'(bus.mw_bubble), 32'(e_bub));
        chk("mw_mem_data", 32'(bus.mw_mem_data), (e_done && !e_wr) ? 32'(rdat) : 32'd0);
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_halted = 0; m_err = 0; m_wr = 0; m_busy = 0; m_stalls = 0;
            m_addr = 0; m_wdata = 0;
        end else begin
            if (e_stall && m_stalls < 65535) m_stalls++;
            if (!e_bub && v && h) m_halted = 1;
            if (m_pend) begin
                if (rdy) m_pend = 0;
                else begin
                    m_busy++;
                    if (m_busy == TMO) begin m_pend = 0; m_err = 1; end
                end
            end else if (e_req && !rdy) begin
                m_pend = 1; m_busy = 0; m_wr = e_wr; m_addr = e_addr; m_wdata = e_wd;
            end
        end
        last_stall = e_stall && !r;
        #1;
    endtask
    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    endtask
    initial begin
        bit v, rd, wr, h, r;
        logic [15:0] a, d;
        do_reset();
        do_reset();
        cyc(0, 1, 1, 0, 0, 16'h0040, 16'h0000, 1, 16'hBEEF);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 16'h0102, 16'h1234, 0, 16'h5555);
        cyc(0, 1, 0, 1, 0, 16'h0102, 16'h1234, 1, 16'h5555);
        chk("store_stalls", 32'(bus.stall_cycles), 32'd3);
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 16'h0200, 16'h0, 0, 16'h0);
        chk("timeout_err", 32'(bus.err), 32'd1);
        cyc(0, 1, 1, 0, 0, 16'h0200, 16'h0, 1, 16'h7777);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 16'h0300, 16'h0, 0, 16'h0);
        cyc(0, 1, 1, 0, 0, 16'h0300, 16'h0, 1, 16'hA5A5);
        chk("late_ok_err", 32'(bus.err), 32'd0);
        do_reset();
        cyc(0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        cyc(0, 1, 0, 0, 1, 16'h0, 16'h0, 0, 16'h0);
        chk("halt_set", 32'(bus.halted), 32'd1);
        cyc(0, 1, 1, 0, 0, 16'h0400, 16'h0, 1, 16'h1111);
        do_reset();
        cyc(0, 1, 1, 0, 0, 16'h0500, 16'h0, 0, 16'h0);
        cyc(0, 1, 1, 0, 0, 16'h0500, 16'h0, 0, 16'h0);
        cyc(1, 1, 1, 0, 0, 16'h0500, 16'h0, 0, 16'h0);
        chk("rst_busy_stalls", 32'(bus.stall_cycles), 32'd0);
        cyc(0, 1, 1, 0, 0, 16'h0600, 16'h0, 1, 16'hC0DE);
        cyc(0, 1, 1, 1, 0, 16'h0700, 16'h9999, 0, 16'h0);
        cyc(0, 1, 1, 1, 0, 16'h0700, 16'h9999, 1, 16'hFFFF);
        last_stall = 0;
        v = 0; rd = 0; wr = 0; h = 0; a = 0; d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                v  = $urandom_range(9) < 8;
                rd = $urandom_range(9) < 4;
                wr = $urandom_range(9) < 3;
                h  = $urandom_range(24) == 0;
                a  = 16'($urandom);
                d  = 16'($urandom);
            end
            r = ($urandom_range(39) == 0) || ((m_halted || m_err) && $urandom_range(7) == 0);
            cyc(r, v, rd, wr, h, a, d, $urandom_range(9) < 4, 16'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
